mode7_outbuf: RTL and testbench
===============================

# mode7_outbuf

Output packing and writeback stage of the softmax pipeline, directly downstream of the mode-7 exponent pair. Each accepted input is one pair of final softmax values (element 2k on `in0`, element 2k+1 on `in1`). The block packs `PAIRS` consecutive pairs into one wide word and writes the words to the output memory at consecutive addresses, with valid/ready backpressure on both sides. It performs no arithmetic on the data.

## Interface
- `DATAWIDTH`, 16: width of one floating-point element (matches `DATAWIDTH`).
- `PAIRS`, 4: input pairs per output word; output word width is W = 2·PAIRS·DATAWIDTH.
- `ADDRW`, 8: output memory address width.

Ports:
- `clk` input 1: single clock; everything is on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle pulse that begins a vector; sampled only in IDLE.
- `base_addr` input ADDRW: first write address; latched on `start`.
- `num_words` input ADDRW+1: number of words to write; latched on `start`.
- `in_valid` input 1: an input pair is present.
- `in_ready` output 1: the block accepts the pair this cycle.
- `in0` input DATAWIDTH: even element.
- `in1` input DATAWIDTH: odd element.
- `mem_wr_en` output 1: a write word is valid.
- `mem_wr_addr` output ADDRW: write address.
- `mem_wr_data` output W: packed word.
- `mem_wr_ready` input 1: the memory accepts the write this cycle.
- `busy` output 1: a vector is in progress.
- `done` output 1: single-cycle completion pulse.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `start` with `num_words`≠0: latch base/count, clear the counters, go to RUN.
  - `start` with `num_words`=0: go to DONE and issue no writes.
- **Input accept:** a pair is accepted when `in_valid && in_ready`.
- **Packing:**
  - Slot counter j runs 0..PAIRS-1.
  - `in0` goes to bits [2j·DW +: DW] and `in1` to bits [(2j+1)·DW +: DW]. Lowest element sits in the lowest bits.
  - Slots 0..PAIRS-2 go into the pack register.
  - The pair in slot PAIRS-1 is merged with the pack register and loaded into the output register on the same edge. The output register then becomes valid and j wraps to 0.
- **`in_ready`:** asserted (RUN) && (packed_words < num_words) && (j ≠ PAIRS-1 || !`mem_wr_en` || `mem_wr_ready`).
  - This is a combinational path from `mem_wr_ready` to `in_ready`. It is required for full throughput.
- **Write side:**
  - `mem_wr_en` equals output-register valid.
  - A write completes when `mem_wr_en && mem_wr_ready`. On completion `mem_wr_addr` increments and written_words increments.
  - The address wraps modulo 2^ADDRW.
  - `mem_wr_data` and `mem_wr_addr` hold stable while `mem_wr_en` is high and `mem_wr_ready` is low.
  - If a completion and a new load happen on the same edge, the new word replaces the old one with no bubble, and the address advances.
- **RUN to DONE:** on the edge where written_words reaches `num_words`.
- **DONE:** lasts one cycle with `done`=1, then returns to IDLE.
- **Extra input:** input beyond `num_words`·PAIRS pairs is never accepted (`in_ready`=0).
- **`start` outside IDLE:** ignored, with no effect on counters.

## Timing
- **Reset values:** all outputs 0, state IDLE, pack register and output register cleared/invalid, counters 0.
- **Reset mid-vector:** the vector is abandoned and any pending word is dropped. The block restarts in IDLE.
- **`busy`:** 1 from the cycle after an accepted `start` through the DONE cycle inclusive; 0 in IDLE.
- **Write latency:** the pair completing a word is accepted at edge t; `mem_wr_en`=1 with that word during cycle t+1.
- **Throughput:** one pair per cycle sustained while `mem_wr_ready`=1. A vector of N words with continuous input takes N·PAIRS accept cycles plus 1 cycle to the last write.
- **`done` timing:** `done`=1 in the cycle after the final write handshake.
- **Zero-length vector:** `done` occurs one cycle after `start`.

## Test plan
1. **Reset:** assert `reset_n`=0 mid-stream, including while `mem_wr_en`=1.
   - All outputs must be 0 immediately (asynchronous).
   - After release, the state is IDLE and no write is issued.
2. **Basic packing:** PAIRS=4, `base_addr`=0x10, `num_words`=2, 8 back-to-back pairs with `in0`=0x3C00+2i and `in1`=0x3C01+2i, `mem_wr_ready`=1.
   - Write at 0x10 with data 0x3C07_3C06_3C05_3C04_3C03_3C02_3C01_3C00.
   - Write at 0x11 with 0x3C0F…0x3C08.
   - `in_ready` stays high throughout.
   - `done` occurs one cycle after the 0x11 write.
3. **Backpressure:** same stimulus with `mem_wr_ready`=0 for 5 cycles after the first `mem_wr_en`.
   - The word and address hold stable.
   - `in_ready` drops only when j=3.
   - All 16 elements arrive intact and in order.
4. **Zero length:** `num_words`=0.
   - `done` occurs the next cycle.
   - `mem_wr_en` never asserts.
   - `in_ready` stays 0.
5. **Address wrap:** ADDRW=8, `base_addr`=0xFF, `num_words`=2 → writes go to 0xFF then 0x00.
6. **Start ignored while busy:** pulse `start` with `base_addr`=0x40 mid-vector.
   - The addresses and count of the current vector are unaffected.
   - Exactly one `done` pulse occurs.

Source files
------------

// File: rtl/mode7_outbuf.sv
// Softmax writeback: packs PAIRS element pairs per word and
// streams the words to output memory at consecutive addresses.
module mode7_outbuf #(
  parameter int DATAWIDTH = 16,
  parameter int PAIRS     = 4,
  parameter int ADDRW     = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [ADDRW-1:0]             base_addr,
  input  logic [ADDRW:0]               num_words,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATAWIDTH-1:0]         in0,
  input  logic [DATAWIDTH-1:0]         in1,
  output logic                         mem_wr_en,
  output logic [ADDRW-1:0]             mem_wr_addr,
  output logic [2*PAIRS*DATAWIDTH-1:0] mem_wr_data,
  input  logic                         mem_wr_ready,
  output logic                         busy,
  output logic                         done
);

  localparam int W  = 2 * PAIRS * DATAWIDTH;
  localparam int JW = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [JW-1:0] LAST = JW'(PAIRS - 1);
  localparam logic [ADDRW:0] ONE = (ADDRW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [ADDRW:0]   count;
  logic [ADDRW:0]   packed_n;
  logic [ADDRW:0]   written;
  logic [JW-1:0]    slot;
  logic [W-1:0]     pack;
  logic [W-1:0]     pack_nxt;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic [ADDRW-1:0] addr;
  logic             last_slot;
  logic             accept;
  logic             wr_fire;

  assign last_slot = (slot == LAST);
  assign wr_fire   = out_valid && mem_wr_ready;

  // The closing pair may enter only if the output slot frees this edge
  assign in_ready = (state == S_RUN)
                 && (packed_n < count)
                 && (!last_slot || !out_valid || mem_wr_ready);
  assign accept   = in_valid && in_ready;

  assign mem_wr_en   = out_valid;
  assign mem_wr_addr = addr;
  assign mem_wr_data = out_data;

  always_comb begin
    pack_nxt = pack;
    for (int s = 0; s < PAIRS; s++) begin
      if (slot == JW'(s)) begin
        pack_nxt[2*s*DATAWIDTH +: 2*DATAWIDTH] = {in1, in0};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      count     <= '0;
      packed_n  <= '0;
      written   <= '0;
      slot      <= '0;
      pack      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      addr      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= base_addr;
            count     <= num_words;
            packed_n  <= '0;
            written   <= '0;
            slot      <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b1;
            if (num_words == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (wr_fire) begin
            out_valid <= 1'b0;
            addr      <= addr + ADDRW'(1);
            written   <= written + ONE;
            if (written + ONE == count) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
          // A load on the same edge as a write overrides the clear
          if (accept) begin
            if (last_slot) begin
              out_data  <= pack_nxt;
              out_valid <= 1'b1;
              slot      <= '0;
              packed_n  <= packed_n + ONE;
            end else begin
              pack <= pack_nxt;
              slot <= slot + JW'(1);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mode7_outbuf.sv
// Scoreboard bench for mode7_outbuf: driver queues expected words,
// a negedge monitor pops/compares and models the handshake rules.
module tb_mode7_outbuf;

  localparam int DW = 16;
  localparam int P  = 4;
  localparam int AW = 8;
  localparam int W  = 2 * P * DW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in0 = '0;
  logic [DW-1:0] in1 = '0;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [W-1:0]  mem_wr_data;
  logic          mem_wr_ready = 1'b0;
  logic          busy;
  logic          done;

  mode7_outbuf #(.DATAWIDTH(DW), .PAIRS(P), .ADDRW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .base_addr(base_addr), .num_words(num_words),
    .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_ready(mem_wr_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   vec_end = 1'b0;

  task automatic check(input string name,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor-side protocol model
  bit            active = 1'b0;
  bit            stall = 1'b0;
  bit            exp_rdy;
  int            acc = 0;
  int            wr = 0;
  int            total = 0;
  int            nwords = 0;
  int            cyc = 0;
  int            done_at = -1;
  int            done_cnt = 0;
  logic [AW-1:0] h_a;
  logic [W-1:0]  h_d;
  exp_t          mon_e;

  always @(negedge clk) begin
    if (!reset_n) begin
      active  = 1'b0;
      stall   = 1'b0;
      done_at = -1;
      acc     = 0;
      wr      = 0;
      total   = 0;
      nwords  = 0;
    end else begin
      check("busy", W'(busy), W'(active));
      exp_rdy = active && (acc < total)
             && !((acc % P == P - 1) && (acc / P > wr)
                  && !mem_wr_ready);
      check("in_ready", W'(in_ready), W'(exp_rdy));
      if (stall) begin
        check("hold_en", W'(mem_wr_en), W'(1));
        check("hold_addr", W'(mem_wr_addr), W'(h_a));
        check("hold_data", mem_wr_data, h_d);
      end
      if (mem_wr_en && mem_wr_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h, none due",
                   mem_wr_addr, mem_wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", W'(mem_wr_addr), W'(mon_e.a));
          check("wr_data", mem_wr_data, mon_e.d);
        end
        wr++;
        if (active && wr == nwords) done_at = cyc + 1;
      end
      if (done || cyc == done_at)
        check("done", W'(done), W'(cyc == done_at));
      if (done) done_cnt++;
      stall = mem_wr_en && !mem_wr_ready;
      h_a   = mem_wr_addr;
      h_d   = mem_wr_data;
      if (in_valid && in_ready) acc++;
      if (start && !active) begin
        active = 1'b1;
        nwords = int'(num_words);
        total  = nwords * P;
        acc    = 0;
        wr     = 0;
        if (nwords == 0) done_at = cyc + 1;
      end else if (cyc == done_at) begin
        active  = 1'b0;
        done_at = -1;
      end
    end
    cyc++;
  end

  task automatic ready_ctl(input int mode);
    int cnt;
    cnt = 0;
    while (!vec_end) begin
      @(posedge clk);
      #1;
      case (mode)
        1: begin
          if (mem_wr_en) cnt++;
          mem_wr_ready = (cnt > 5);
        end
        2: mem_wr_ready = ($urandom_range(0, 2) != 0);
        default: mem_wr_ready = 1'b1;
      endcase
    end
    mem_wr_ready = 1'b1;
  endtask

  task automatic run_vector(input logic [AW-1:0] base, input int nw,
                            input int rmode, input bit gaps,
                            input bit det, input bit mid_start);
    logic [DW-1:0] a0[$];
    logic [DW-1:0] a1[$];
    logic [W-1:0]  d;
    int            idx;
    int            guard;
    int            d0;
    bit            seen;
    for (int i = 0; i < nw * P; i++) begin
      if (det) begin
        a0.push_back(DW'(16'h3C00 + 2 * i));
        a1.push_back(DW'(16'h3C01 + 2 * i));
      end else begin
        a0.push_back(DW'($urandom));
        a1.push_back(DW'($urandom));
      end
    end
    for (int k = 0; k < nw; k++) begin
      d = '0;
      for (int p = 0; p < P; p++) begin
        d = d | (W'(a0[k*P+p]) << (2 * p * DW));
        d = d | (W'(a1[k*P+p]) << ((2 * p + 1) * DW));
      end
      exp_q.push_back('{a: AW'((int'(base) + k) % 256), d: d});
    end
    d0 = done_cnt;
    vec_end = 1'b0;
    mem_wr_ready = (rmode != 1);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = base;
    num_words = (AW+1)'(nw);
    @(posedge clk);
    #1;
    start = 1'b0;
    fork
      begin
        idx = 0;
        guard = 0;
        while (idx < nw * P && guard < 2000) begin
          in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
          in0 = a0[idx];
          in1 = a1[idx];
          @(negedge clk);
          if (in_valid && in_ready) idx++;
          @(posedge clk);
          #1;
          guard++;
        end
        if (idx < nw * P) begin
          n_checks++;
          n_fail++;
          $display("FAIL feed_timeout: accepted %0d of %0d", idx, nw * P);
        end
        in_valid = 1'b1;
        in0 = 16'hDEAD;
        in1 = 16'hBEEF;
        seen = 1'b0;
        guard = 0;
        while (!seen && guard < 2000) begin
          @(negedge clk);
          if (done) seen = 1'b1;
          guard++;
        end
        if (!seen) begin
          n_checks++;
          n_fail++;
          $display("FAIL done_timeout: done %0d required 1", done);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vec_end = 1'b1;
      end
      ready_ctl(rmode);
      begin
        if (mid_start) begin
          repeat (6) @(posedge clk);
          #1;
          start = 1'b1;
          base_addr = 8'h40;
          num_words = 1;
          @(posedge clk);
          #1;
          start = 1'b0;
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("done_count", W'(done_cnt - d0), W'(1));
    check("queue_empty", W'(exp_q.size()), W'(0));
  endtask

  task automatic reset_mid();
    mem_wr_ready = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 8'h20;
    num_words = 2;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in0 = DW'(i);
      in1 = DW'(i + 100);
      @(posedge clk);
      #1;
    end
    check("pre_reset_en", W'(mem_wr_en), W'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_wr_en", W'(mem_wr_en), W'(0));
    check("rst_addr", W'(mem_wr_addr), W'(0));
    check("rst_data", mem_wr_data, '0);
    check("rst_in_ready", W'(in_ready), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    mem_wr_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_wr_en", W'(mem_wr_en), W'(0));
    end
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("init_wr_en", W'(mem_wr_en), W'(0));
    check("init_in_ready", W'(in_ready), W'(0));
    check("init_busy", W'(busy), W'(0));
    check("init_done", W'(done), W'(0));
    check("init_data", mem_wr_data, '0);
    reset_n = 1'b1;
    run_vector(8'h10, 2, 0, 1'b0, 1'b1, 1'b0);
    run_vector(8'h10, 2, 1, 1'b0, 1'b1, 1'b0);
    run_vector(8'h33, 0, 0, 1'b0, 1'b0, 1'b0);
    run_vector(8'hFF, 2, 0, 1'b1, 1'b0, 1'b0);
    run_vector(8'h80, 3, 2, 1'b0, 1'b0, 1'b1);
    reset_mid();
    for (int t = 0; t < 6; t++) begin
      run_vector(AW'($urandom), $urandom_range(1, 5), 2,
                 1'b1, 1'b0, 1'b0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
